// File: rtl/axis_pkg.sv
// Shared definitions for the LFSR test-pattern AXI-Stream link: polynomials, seeds, lock states.
package axis_pkg;

  // x^64+x^63+x^61+x^60+1, Fibonacci form shifting towards the MSB
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  // x^16+x^14+x^13+x^11+1, Fibonacci form shifting towards the LSB
  localparam logic [15:0] BP_TAPS = 16'h002D;
  localparam logic [15:0] BP_SEED = 16'hACE1;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_st_e;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {s[62:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] bp_next(input logic [15:0] s);
    return {^(s & BP_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream style beat interface carrying the LFSR test pattern.
interface axis_if #(
  parameter int DATAW = 64
);
  logic [DATAW-1:0] data;
  logic             vld;
  logic             last;
  logic             rdy;

  modport master (output data, vld, last, input rdy);
  modport slave  (input data, vld, last, output rdy);
  modport in     (input data, vld, last, output rdy);
endinterface

// File: rtl/lfsr_64bit_ld.sv
// Loadable 64-bit LFSR that holds the checker's prediction of the next source word.
module lfsr_64bit_ld
  import axis_pkg::*;
(
  input  logic        clk,
  input  logic        a_rst,
  input  logic        ld,
  input  logic [63:0] ld_val,
  input  logic        adv,
  output logic [63:0] q
);

  logic [63:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld)       q_d = ld_val;
    else if (adv) q_d = lfsr_next(q_q);
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/axis_chk.sv
// LFSR stream checker/sink: lock FSM, framing check, counters, optional back-pressure.
// Define AXIS_CHK_BP_EN to drive rdy from a 16-bit pseudo-random LFSR.
//
// state       | meaning
// ST_UNLOCKED | waiting for an accepted beat to seed the prediction
// ST_LOCKED   | prediction free-runs with the source; beats are compared
module axis_chk
  import axis_pkg::*;
#(
  parameter int N      = 16,
  parameter int DATAW  = 64,
  parameter int MAXMIS = 4
) (
  input  logic        clk,
  input  logic        a_rst,
  axis_if.in          lfsr_in,
  output logic        locked,
  output logic        data_err,
  output logic        last_err,
  output logic [31:0] frm_cnt,
  output logic [15:0] err_cnt
);

  localparam int  IW     = $clog2(N);
  localparam int  MW     = $clog2(MAXMIS + 1);
  localparam int  DW     = (DATAW < 64) ? DATAW : 64;
  localparam bit  CHK_EN = (DATAW == 64);

  lock_st_e    st_q, st_d;
  logic [MW-1:0] mis_q, mis_d;
  logic [IW-1:0] idx_q, idx_d;
  logic        rdy_q, rdy_d;
  logic        data_err_q, data_err_d;
  logic        last_err_q, last_err_d;
  logic [31:0] frm_q, frm_d;
  logic [15:0] err_q, err_d;
  logic [16:0] err_sum;
  logic [63:0] data64, pred, pred_ld_val;
  logic        pred_ld, acc;

  assign acc = lfsr_in.vld && rdy_q;

  always_comb begin
    data64         = '0;
    data64[DW-1:0] = lfsr_in.data[DW-1:0];
  end

  assign pred_ld_val = lfsr_next(data64);

  lfsr_64bit_ld u_pred (
    .clk    (clk),
    .a_rst  (a_rst),
    .ld     (pred_ld),
    .ld_val (pred_ld_val),
    .adv    (st_q == ST_LOCKED),
    .q      (pred)
  );

  // Lock FSM: the sync beat itself is never compared
  always_comb begin
    st_d       = st_q;
    mis_d      = mis_q;
    pred_ld    = 1'b0;
    data_err_d = 1'b0;
    if (CHK_EN && acc) begin
      if (st_q == ST_UNLOCKED) begin
        pred_ld = 1'b1;
        st_d    = ST_LOCKED;
      end else if (data64 != pred) begin
        data_err_d = 1'b1;
        if (mis_q == MW'(MAXMIS - 1)) begin
          st_d  = ST_UNLOCKED;
          mis_d = '0;
        end else begin
          mis_d = mis_q + 1'b1;
        end
      end else begin
        mis_d = '0;
      end
    end
  end

  // Framing, counters; a received last always realigns the beat index
  always_comb begin
    idx_d      = idx_q;
    last_err_d = 1'b0;
    frm_d      = frm_q;
    if (acc) begin
      last_err_d = lfsr_in.last != (idx_q == IW'(N - 1));
      if (lfsr_in.last || idx_q == IW'(N - 1)) idx_d = '0;
      else                                     idx_d = idx_q + 1'b1;
      if (lfsr_in.last) frm_d = frm_q + 32'd1;
    end
    err_sum = {1'b0, err_q} + {16'd0, data_err_d} + {16'd0, last_err_d};
    err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

`ifdef AXIS_CHK_BP_EN
  logic [15:0] bp_q, bp_d;

  always_comb begin
    bp_d  = bp_next(bp_q);
    rdy_d = bp_q[0];
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) bp_q <= BP_SEED;
    else       bp_q <= bp_d;
  end
`else
  always_comb rdy_d = 1'b1;
`endif

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      st_q       <= ST_UNLOCKED;
      mis_q      <= '0;
      idx_q      <= '0;
      rdy_q      <= 1'b0;
      data_err_q <= 1'b0;
      last_err_q <= 1'b0;
      frm_q      <= '0;
      err_q      <= '0;
    end else begin
      st_q       <= st_d;
      mis_q      <= mis_d;
      idx_q      <= idx_d;
      rdy_q      <= rdy_d;
      data_err_q <= data_err_d;
      last_err_q <= last_err_d;
      frm_q      <= frm_d;
      err_q      <= err_d;
    end
  end

  assign lfsr_in.rdy = rdy_q;
  assign locked      = (st_q == ST_LOCKED);
  assign data_err    = data_err_q;
  assign last_err    = last_err_q;
  assign frm_cnt     = frm_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_axis_chk.sv
// Self-checking bench for axis_chk: free-running LFSR source model plus a pulse scoreboard.
module tb_axis_chk;

  logic        clk;
  logic        a_rst;
  logic        locked, data_err, last_err;
  logic [31:0] frm_cnt;
  logic [15:0] err_cnt;

  axis_if #(.DATAW(64)) bus ();

  axis_chk #(.N(16), .DATAW(64), .MAXMIS(4)) dut (
    .clk      (clk),
    .a_rst    (a_rst),
    .lfsr_in  (bus),
    .locked   (locked),
    .data_err (data_err),
    .last_err (last_err),
    .frm_cnt  (frm_cnt),
    .err_cnt  (err_cnt)
  );

  typedef struct packed {
    logic de;
    logic le;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] gen;
  int          n_checks;
  int          n_fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] src_next(input logic [63:0] s);
    logic fb;
    fb = s[63] ^ s[62] ^ s[60] ^ s[59];
    return {s[62:0], fb};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // One clock of source activity; pulses from this cycle are checked right after the edge
  task automatic step(input bit v, input logic [63:0] m, input bit l,
                      input bit ede, input bit ele, output bit acc);
    exp_t e, got;
    bus.vld  = v;
    bus.data = gen ^ m;
    bus.last = l;
    acc  = v && (bus.rdy === 1'b1);
    e.de = acc ? ede : 1'b0;
    e.le = acc ? ele : 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    gen = src_next(gen);
    bus.vld = 1'b0;
    got = sb.pop_front();
    n_checks += 2;
    if (data_err !== got.de) begin
      n_fails++;
      $display("FAIL data_err: got %b expected %b at %0t", data_err, got.de, $time);
    end
    if (last_err !== got.le) begin
      n_fails++;
      $display("FAIL last_err: got %b expected %b at %0t", last_err, got.le, $time);
    end
  endtask

  task automatic send_beat(input logic [63:0] m, input bit l, input bit ede, input bit ele);
    bit acc;
    int t;
    t = 0;
    acc = 1'b0;
    while (!acc && t < 64) begin
      step(1'b1, m, l, ede, ele, acc);
      t++;
    end
    if (!acc) begin
      n_checks++;
      n_fails++;
      $display("FAIL beat_accept_timeout: got no accept expected accept at %0t", $time);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic do_reset();
    bus.vld = 1'b0;
    a_rst   = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      gen = src_next(gen);
    end
    a_rst = 1'b0;
    idle(1);
  endtask

  task automatic test_reset();
    a_rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      gen = src_next(gen);
    end
    chk("rst_rdy", 32'(bus.rdy), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_data_err", 32'(data_err), 32'd0);
    chk("rst_last_err", 32'(last_err), 32'd0);
    chk("rst_frm_cnt", frm_cnt, 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    a_rst = 1'b0;
    idle(1);
    chk("rdy_after_release", 32'(bus.rdy), 32'd1);
    chk("locked_before_sync", 32'(locked), 32'd0);
  endtask

  task automatic test_clean();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      send_beat(64'd0, (i % 16) == 15, 1'b0, 1'b0);
      if (i == 0) chk("clean_locked_after_sync", 32'(locked), 32'd1);
    end
    chk("clean_frm_cnt", frm_cnt, 32'd4);
    chk("clean_err_cnt", 32'(err_cnt), 32'd0);
    chk("clean_locked", 32'(locked), 32'd1);
  endtask

  task automatic test_single_flip();
    do_reset();
    for (int i = 0; i < 64; i++)
      send_beat((i == 20) ? 64'd1 : 64'd0, (i % 16) == 15, i == 20, 1'b0);
    chk("flip_err_cnt", 32'(err_cnt), 32'd1);
    chk("flip_locked", 32'(locked), 32'd1);
    chk("flip_frm_cnt", frm_cnt, 32'd4);
  endtask

  task automatic test_burst();
    do_reset();
    for (int i = 0; i < 48; i++) begin
      send_beat((i >= 30 && i <= 33) ? 64'hFF : 64'd0, (i % 16) == 15,
                i >= 30 && i <= 33, 1'b0);
      if (i == 32) chk("burst_locked_at_32", 32'(locked), 32'd1);
      if (i == 33) chk("burst_unlocked_at_33", 32'(locked), 32'd0);
      if (i == 34) chk("burst_relocked_at_34", 32'(locked), 32'd1);
    end
    chk("burst_err_cnt", 32'(err_cnt), 32'd4);
    chk("burst_frm_cnt", frm_cnt, 32'd3);
  endtask

  task automatic test_last_shift();
    do_reset();
    for (int i = 0; i < 26; i++) begin
      send_beat(64'd0, i == 9, 1'b0, i == 9 || i == 25);
      if (i == 9) chk("shift_frm_after_9", frm_cnt, 32'd1);
    end
    chk("shift_err_cnt", 32'(err_cnt), 32'd2);
    chk("shift_frm_cnt", frm_cnt, 32'd1);
    chk("shift_locked", 32'(locked), 32'd1);
  endtask

  task automatic test_gaps();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      idle(3);
      send_beat(64'd0, (i % 16) == 15, 1'b0, 1'b0);
    end
    chk("gaps_err_cnt", 32'(err_cnt), 32'd0);
    chk("gaps_frm_cnt", frm_cnt, 32'd2);
    chk("gaps_locked", 32'(locked), 32'd1);
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 23; i++) send_beat(64'd0, (i % 16) == 15, 1'b0, 1'b0);
    chk("mid_frm_before", frm_cnt, 32'd1);
    chk("mid_locked_before", 32'(locked), 32'd1);
    bus.vld  = 1'b1;
    bus.data = gen;
    bus.last = 1'b0;
    #2;
    a_rst = 1'b1;
    #1;
    chk("mid_async_locked", 32'(locked), 32'd0);
    chk("mid_async_frm", frm_cnt, 32'd0);
    chk("mid_async_rdy", 32'(bus.rdy), 32'd0);
    @(posedge clk);
    #1;
    gen = src_next(gen);
    bus.vld = 1'b0;
    chk("mid_edge_data_err", 32'(data_err), 32'd0);
    chk("mid_edge_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1;
    gen = src_next(gen);
    a_rst = 1'b0;
    idle(1);
    for (int i = 0; i < 16; i++) begin
      send_beat(64'd0, i == 15, 1'b0, 1'b0);
      if (i == 0) chk("mid_relocked", 32'(locked), 32'd1);
    end
    chk("mid_frm_restart", frm_cnt, 32'd1);
    chk("mid_err_cnt", 32'(err_cnt), 32'd0);
  endtask

  // Every beat carries last (always misplaced) and corrupted data: 9 errors per 5 beats
  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 36600; i++) begin
      send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, (i % 5) != 0, 1'b1);
      if (i == 4999) chk("sat_err_cnt_mid", 32'(err_cnt), 32'd9000);
    end
    chk("sat_err_cnt", 32'(err_cnt), 32'hFFFF);
    chk("sat_frm_cnt", frm_cnt, 32'd36600);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    gen      = 64'hFEDC_BA98_7654_3210;
    a_rst    = 1'b0;
    bus.vld  = 1'b0;
    bus.last = 1'b0;
    bus.data = '0;
    #2;
    test_reset();
    test_clean();
    test_single_flip();
    test_burst();
    test_last_shift();
    test_gaps();
    test_mid_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
